// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and helpers for the game-flow controller
package game_pkg;

  // Widest lane vector the popcount helper accepts
  localparam int MAX_LANES = 8;

  // Default width of the score and combo counters
  localparam int SCORE_W_DEFAULT = 16;

  // Screen-level game states
  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } game_state_t;

  // Number of set bits in a lane vector; narrower vectors are zero-extended by the caller
  function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - rising-edge detector producing a registered one-cycle pulse per key press
module key_edge (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember the last sampled level and register the rise so a held key yields exactly one pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - menu/play/pause/win/lose sequencer with miss, score and combo tracking
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int MAX_MISS  = 7,
  parameter int MISS_W    = $clog2(MAX_MISS + 1),
  parameter int NUM_LANES = 4,
  parameter int SCORE_W   = SCORE_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 key_1,
  input  logic                 key_2,
  input  logic [NUM_LANES-1:0] hit,
  input  logic [NUM_LANES-1:0] miss,
  input  logic                 done,
  output logic                 interface_sel,
  output logic                 map,
  output logic                 paused,
  output logic                 win,
  output logic                 lose,
  output logic [MISS_W-1:0]    total_miss,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   combo,
  output logic [SCORE_W-1:0]   max_combo
);

  localparam logic [MISS_W+3:0] MISS_LIMIT_EXT = (MISS_W + 4)'(MAX_MISS);
  localparam logic [MISS_W-1:0] MISS_LIMIT     = MISS_W'(MAX_MISS);

  game_state_t state, next_state;

  logic key_1_rise, key_2_rise;
  logic clear_counts, count_en;

  logic [3:0]         hit_cnt, miss_cnt;
  logic [MISS_W+3:0]  miss_sum;
  logic [MISS_W-1:0]  miss_next;
  logic [SCORE_W:0]   score_sum, combo_sum;
  logic [SCORE_W-1:0] score_next, combo_next, max_next;

  key_edge u_key_1_edge (
    .clk    (clk),
    .resetn (resetn),
    .level  (key_1),
    .rise   (key_1_rise)
  );

  key_edge u_key_2_edge (
    .clk    (clk),
    .resetn (resetn),
    .level  (key_2),
    .rise   (key_2_rise)
  );

  assign hit_cnt  = popcount(MAX_LANES'(hit));
  assign miss_cnt = popcount(MAX_LANES'(miss));

  // Saturating next values of every counter, assuming this cycle counts
  always_comb begin
    miss_sum  = {4'b0000, total_miss} + {{MISS_W{1'b0}}, miss_cnt};
    miss_next = (miss_sum >= MISS_LIMIT_EXT) ? MISS_LIMIT : miss_sum[MISS_W-1:0];

    score_sum  = {1'b0, score} + (SCORE_W + 1)'(hit_cnt);
    score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // Any miss breaks the run, even when hits land on the same cycle
    combo_sum = {1'b0, combo} + (SCORE_W + 1)'(hit_cnt);
    if (|miss) begin
      combo_next = '0;
    end else if (combo_sum[SCORE_W]) begin
      combo_next = {SCORE_W{1'b1}};
    end else begin
      combo_next = combo_sum[SCORE_W-1:0];
    end

    max_next = (combo_next > max_combo) ? combo_next : max_combo;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_MENU;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection and counter enables; quitting wins over losing, losing over finishing
  always_comb begin
    next_state   = state;
    clear_counts = 1'b0;
    count_en     = 1'b0;
    case (state)
      ST_MENU: begin
        if (key_1_rise) begin
          next_state   = ST_PLAY;
          clear_counts = 1'b1;
        end
      end
      ST_PLAY: begin
        count_en = 1'b1;
        if (key_2_rise) begin
          next_state = ST_MENU;
        end else if (miss_next == MISS_LIMIT) begin
          next_state = ST_LOSE;
        end else if (done) begin
          next_state = ST_WIN;
        end else if (key_1_rise) begin
          next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (key_2_rise) begin
          next_state = ST_MENU;
        end else if (key_1_rise) begin
          next_state = ST_PLAY;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (key_2_rise) begin
          next_state = ST_MENU;
        end
      end
      default: begin
        next_state = ST_MENU;
      end
    endcase
  end

  // Game counters: cleared when a new game starts, advanced only while playing, frozen otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      total_miss <= '0;
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
    end else if (clear_counts) begin
      total_miss <= '0;
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
    end else if (count_en) begin
      total_miss <= miss_next;
      score      <= score_next;
      combo      <= combo_next;
      max_combo  <= max_next;
    end
  end

  // Screen selects decoded straight from the state register
  assign interface_sel = (state == ST_MENU);
  assign map           = (state == ST_PLAY) || (state == ST_PAUSE);
  assign paused        = (state == ST_PAUSE);
  assign win           = (state == ST_WIN);
  assign lose          = (state == ST_LOSE);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed and randomized checks of game_flow_ctrl against a behavioural model
module tb_game_flow_ctrl;

  localparam int MAX_MISS  = 3;
  localparam int NUM_LANES = 4;
  localparam int SCORE_W   = 16;
  localparam int MISS_W    = $clog2(MAX_MISS + 1);
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  localparam int M_MENU  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_WIN   = 3;
  localparam int M_LOSE  = 4;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 key_1 = 1'b0;
  logic                 key_2 = 1'b0;
  logic [NUM_LANES-1:0] hit = '0;
  logic [NUM_LANES-1:0] miss = '0;
  logic                 done = 1'b0;
  logic                 interface_sel, map, paused, win, lose;
  logic [MISS_W-1:0]    total_miss;
  logic [SCORE_W-1:0]   score, combo, max_combo;

  int n_checks = 0;
  int n_fail   = 0;

  int m_state, m_miss, m_score, m_combo, m_max;
  bit m_last1, m_last2, m_pend1, m_pend2;

  game_flow_ctrl #(
    .MAX_MISS  (MAX_MISS),
    .MISS_W    (MISS_W),
    .NUM_LANES (NUM_LANES),
    .SCORE_W   (SCORE_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .key_1         (key_1),
    .key_2         (key_2),
    .hit           (hit),
    .miss          (miss),
    .done          (done),
    .interface_sel (interface_sel),
    .map           (map),
    .paused        (paused),
    .win           (win),
    .lose          (lose),
    .total_miss    (total_miss),
    .score         (score),
    .combo         (combo),
    .max_combo     (max_combo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_MENU;
    m_miss  = 0;
    m_score = 0;
    m_combo = 0;
    m_max   = 0;
    m_last1 = 0;
    m_last2 = 0;
    m_pend1 = 0;
    m_pend2 = 0;
  endtask

  // One clock edge of game behaviour; a key press acts one edge after it is first seen
  task automatic model_step();
    bit a1, a2;
    int nh, nm;
    a1 = m_pend1;
    a2 = m_pend2;
    m_pend1 = key_1 && !m_last1;
    m_pend2 = key_2 && !m_last2;
    m_last1 = key_1;
    m_last2 = key_2;
    nh = $countones(hit);
    nm = $countones(miss);
    case (m_state)
      M_MENU: if (a1) begin
        m_state = M_PLAY;
        m_miss = 0; m_score = 0; m_combo = 0; m_max = 0;
      end
      M_PLAY: begin
        m_miss  = (m_miss + nm > MAX_MISS) ? MAX_MISS : m_miss + nm;
        m_score = (m_score + nh > SCORE_MAX) ? SCORE_MAX : m_score + nh;
        if (nm != 0) m_combo = 0;
        else m_combo = (m_combo + nh > SCORE_MAX) ? SCORE_MAX : m_combo + nh;
        if (m_combo > m_max) m_max = m_combo;
        if (a2) m_state = M_MENU;
        else if (m_miss >= MAX_MISS) m_state = M_LOSE;
        else if (done) m_state = M_WIN;
        else if (a1) m_state = M_PAUSE;
      end
      M_PAUSE: begin
        if (a2) m_state = M_MENU;
        else if (a1) m_state = M_PLAY;
      end
      default: if (a2) m_state = M_MENU;
    endcase
  endtask

  task automatic compare_all();
    check("interface", interface_sel, m_state == M_MENU);
    check("map", map, (m_state == M_PLAY) || (m_state == M_PAUSE));
    check("paused", paused, m_state == M_PAUSE);
    check("win", win, m_state == M_WIN);
    check("lose", lose, m_state == M_LOSE);
    check("total_miss", total_miss, m_miss);
    check("score", score, m_score);
    check("combo", combo, m_combo);
    check("max_combo", max_combo, m_max);
  endtask

  task automatic cycle(input bit k1, input bit k2, input logic [3:0] h, input logic [3:0] m, input bit d);
    @(negedge clk);
    key_1 = k1; key_2 = k2; hit = h; miss = m; done = d;
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic press(input int which);
    cycle(which == 1, which == 2, 4'b0, 4'b0, 1'b0);
    cycle(which == 1, which == 2, 4'b0, 4'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    key_1 = 0; key_2 = 0; hit = '0; miss = '0; done = 0;
    #1 model_reset();
    compare_all();
    check("rst_interface", interface_sel, 1);
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bit r1, r2;
    logic [3:0] rh, rm;
    bit rd;
    model_reset();
    #3 compare_all();
    check("reset_interface", interface_sel, 1);
    @(negedge clk);
    resetn = 1'b1;

    // Held key_1 gives exactly one move to PLAY
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 4'b0, 4'b0, 1'b0);
    check("hold_map", map, 1);
    check("hold_paused", paused, 0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0, 1'b0);

    // Combo broken by a miss on the same cycle as a hit
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'b1111, 4'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 4'b0100, 1'b0);
    check("mix_score", score, 13);
    check("mix_combo", combo, 0);
    check("mix_max", max_combo, 12);
    check("mix_miss", total_miss, 1);

    // Pause drops strobes, second press resumes
    press(1);
    check("pause_paused", paused, 1);
    check("pause_map", map, 1);
    cycle(1'b0, 1'b0, 4'b0, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, 4'b1, 4'b0011, 1'b1);
    check("pause_miss", total_miss, 1);
    press(1);
    check("resume_map", map, 1);
    check("resume_paused", paused, 0);

    // Quit, restart and lose on the limit
    press(2);
    check("quit_interface", interface_sel, 1);
    press(1);
    check("restart_miss", total_miss, 0);
    check("restart_score", score, 0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0011, 1'b0);
    check("lim_miss2", total_miss, 2);
    check("lim_lose0", lose, 0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0001, 1'b0);
    check("lim_miss3", total_miss, 3);
    check("lim_lose1", lose, 1);
    cycle(1'b0, 1'b0, 4'b0, 4'b0011, 1'b0);
    check("lim_hold", total_miss, 3);

    // done together with the limiting miss resolves to LOSE
    press(2);
    press(1);
    cycle(1'b0, 1'b0, 4'b0, 4'b0011, 1'b0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0001, 1'b1);
    check("done_lose", lose, 1);
    check("done_nowin", win, 0);

    // done alone wins, counters freeze until the next start
    press(2);
    press(1);
    cycle(1'b0, 1'b0, 4'b0011, 4'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0, 1'b1);
    check("win", win, 1);
    cycle(1'b0, 1'b0, 4'b1111, 4'b0, 1'b0);
    check("win_frozen", score, 2);
    press(2);
    check("menu_interface", interface_sel, 1);
    check("menu_kept", score, 2);
    press(1);
    check("start_clear", score, 0);

    // Mid-game reset with score 40 and combo 5
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'b1111, 4'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0111, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, 4'b1111, 4'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 4'b0, 1'b0);
    check("pre_rst_score", score, 40);
    check("pre_rst_combo", combo, 5);
    async_reset();

    // Randomized play against the model
    r1 = 0; r2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) r1 = !r1;
      if ($urandom_range(0, 39) == 0) r2 = !r2;
      rh = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      rm = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      rd = ($urandom_range(0, 59) == 0);
      cycle(r1, r2, rh, rm, rd);
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        r1 = 0; r2 = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
